// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor, valid/ready on both sides.
// Ports: clk, rst (async, active-high); in_valid/in_ready, in_a, in_b, in_cin, in_sub;
//   out_valid/out_ready, out_sum, out_cout, out_ovf, out_cnt (ops in flight).
module cla_pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_a,
  input  logic [WIDTH-1:0]                in_b,
  input  logic                            in_cin,
  input  logic                            in_sub,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [WIDTH-1:0]                out_sum,
  output logic                            out_cout,
  output logic                            out_ovf,
  output logic [$clog2(STAGES+2)-1:0]     out_cnt
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int CW    = $clog2(STAGES + 2);

  // Stage 0 is the input register; stage k (k>=1) holds chunks 0..k-1 resolved.
  logic [STAGES:0]  v;
  logic [STAGES:0]  ld;
  logic [STAGES:0]  c_q;
  logic [WIDTH-1:0] a_q [STAGES+1];
  logic [WIDTH-1:0] b_q [STAGES+1];
  logic [WIDTH-1:0] s_q [STAGES+1];
  logic [CHUNK:0]   res [STAGES];
  logic [WIDTH-1:0] sn  [STAGES];

  // Chunk sum built from 4-bit lookahead groups; group carries ripple.
  function automatic logic [CHUNK:0] cla(
    input logic [CHUNK-1:0] a,
    input logic [CHUNK-1:0] b,
    input logic             ci
  );
    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK-1:0] s;
    logic             cg;
    logic             gg;
    logic             gp;
    g  = a & b;
    p  = a ^ b;
    s  = '0;
    cg = ci;
    for (int base = 0; base < CHUNK; base += 4) begin
      gg = 1'b0;
      gp = 1'b1;
      for (int j = 0; j < 4; j++) begin
        if (base + j < CHUNK) begin
          s[base+j] = p[base+j] ^ (gg | (gp & cg));
          gg = g[base+j] | (p[base+j] & gg);
          gp = gp & p[base+j];
        end
      end
      cg = gg | (gp & cg);
    end
    return {cg, s};
  endfunction

  // Load enables walk down from the output so bubbles collapse.
  always_comb begin
    ld = '0;
    ld[STAGES] = !v[STAGES] || out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ld[k] = !v[k] || ld[k+1];
    end
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      res[k] = cla(a_q[k][k*CHUNK +: CHUNK],
                   b_q[k][k*CHUNK +: CHUNK],
                   c_q[k]);
      sn[k] = s_q[k];
      sn[k][k*CHUNK +: CHUNK] = res[k][CHUNK-1:0];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v   <= '0;
      c_q <= '0;
      for (int k = 0; k <= STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      if (ld[0]) begin
        v[0] <= in_valid;
        if (in_valid) begin
          a_q[0] <= in_a;
          b_q[0] <= in_b ^ {WIDTH{in_sub}};
          c_q[0] <= in_sub | in_cin;
          s_q[0] <= '0;
        end
      end
      for (int k = 1; k <= STAGES; k++) begin
        if (ld[k]) begin
          v[k] <= v[k-1];
          if (v[k-1]) begin
            a_q[k] <= a_q[k-1];
            b_q[k] <= b_q[k-1];
            c_q[k] <= res[k-1][CHUNK];
            s_q[k] <= sn[k-1];
          end
        end
      end
    end
  end

  assign in_ready  = !rst && ld[0];
  assign out_valid = v[STAGES];
  assign out_sum   = s_q[STAGES];
  assign out_cout  = c_q[STAGES];
  assign out_ovf   = (a_q[STAGES][WIDTH-1] == b_q[STAGES][WIDTH-1])
                  && (s_q[STAGES][WIDTH-1] != a_q[STAGES][WIDTH-1]);
  assign out_cnt   = CW'($countones(v));

endmodule

// File: tb/tb_cla_pipe_adder.sv
// tb_cla_pipe_adder: random + directed checks of cla_pipe_adder against an
// arithmetic model, plus WIDTH=8 sweeps at STAGES=1,2,8.
module tb_cla_pipe_adder;

  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] in_a = 0;
  logic [31:0] in_b = 0;
  logic        in_cin = 0;
  logic        in_sub = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] out_sum;
  logic        out_cout;
  logic        out_ovf;
  logic [2:0]  out_cnt;

  logic        sw_valid = 0;
  logic [7:0]  sw_a = 0;
  logic [7:0]  sw_b = 0;
  logic        sw_cin = 0;
  logic        sw_sub = 0;
  logic        sw_rdy [3];
  logic        sw_ov  [3];
  logic [7:0]  sw_sum [3];
  logic        sw_co  [3];
  logic        sw_of  [3];
  logic [1:0]  c1;
  logic [1:0]  c2;
  logic [3:0]  c8;

  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;
  int cyc     = 0;

  typedef struct {
    int         due;
    logic [9:0] e;
  } sw_t;

  logic [33:0] exp_q [$];
  sw_t         swq [3][$];
  int          sws [3] = '{1, 2, 8};

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(32), .STAGES(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .out_cnt(out_cnt)
  );

  cla_pipe_adder #(.WIDTH(8), .STAGES(1)) u_s1 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(sw_rdy[0]),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov[0]), .out_ready(1'b1),
    .out_sum(sw_sum[0]), .out_cout(sw_co[0]), .out_ovf(sw_of[0]),
    .out_cnt(c1)
  );

  cla_pipe_adder #(.WIDTH(8), .STAGES(2)) u_s2 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(sw_rdy[1]),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov[1]), .out_ready(1'b1),
    .out_sum(sw_sum[1]), .out_cout(sw_co[1]), .out_ovf(sw_of[1]),
    .out_cnt(c2)
  );

  cla_pipe_adder #(.WIDTH(8), .STAGES(8)) u_s8 (
    .clk(clk), .rst(rst),
    .in_valid(sw_valid), .in_ready(sw_rdy[2]),
    .in_a(sw_a), .in_b(sw_b), .in_cin(sw_cin), .in_sub(sw_sub),
    .out_valid(sw_ov[2]), .out_ready(1'b1),
    .out_sum(sw_sum[2]), .out_cout(sw_co[2]), .out_ovf(sw_of[2]),
    .out_cnt(c8)
  );

  // Returns {ovf, cout, sum} from plain integer arithmetic on w-bit operands.
  function automatic logic [33:0] model(int w, logic [31:0] a, logic [31:0] b,
                                        logic cin, logic sub);
    longint m, ua, ub, sa, sb, r, sr;
    logic   co, ov;
    m  = longint'(1) << w;
    ua = longint'(a) & (m - 1);
    ub = longint'(b) & (m - 1);
    sa = (ua >= m / 2) ? ua - m : ua;
    sb = (ub >= m / 2) ? ub - m : ub;
    if (sub) begin
      r  = ua - ub;
      sr = sa - sb;
      co = (ua >= ub);
    end else begin
      r  = ua + ub + longint'(cin);
      sr = sa + sb + longint'(cin);
      co = (r >= m);
    end
    ov = (sr >= m / 2) || (sr < -(m / 2));
    return {ov, co, 32'(r & (m - 1))};
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Compare process: scoreboards for the main DUT and the three sweep DUTs.
  initial begin
    logic        hold;
    logic [33:0] hv;
    logic [33:0] e;
    logic [3:0]  swc;
    sw_t         se;
    hold = 0;
    hv   = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        for (int i = 0; i < 3; i++) swq[i].delete();
        hold = 0;
      end else begin
        chk("cnt", 64'(out_cnt), 64'(exp_q.size()));
        chk("in_ready", 64'(in_ready),
            64'((exp_q.size() < 5) || out_ready));
        if (hold)
          chk("hold", {out_valid, out_ovf, out_cout, out_sum}, {1'b1, hv});
        hold = out_valid && !out_ready;
        hv   = {out_ovf, out_cout, out_sum};
        if (in_valid && in_ready) begin
          exp_q.push_back(model(32, in_a, in_b, in_cin, in_sub));
          n_acc++;
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected result", 64'(out_valid), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("result", {out_ovf, out_cout, out_sum}, e);
          end
        end
        for (int i = 0; i < 3; i++) begin
          swc = (i == 0) ? {2'b0, c1} : (i == 1) ? {2'b0, c2} : c8;
          chk("sw cnt", 64'(swc), 64'(swq[i].size()));
          chk("sw in_ready", 64'(sw_rdy[i]), 64'(1));
          if (sw_valid && sw_rdy[i]) begin
            e = model(8, {24'b0, sw_a}, {24'b0, sw_b}, sw_cin, sw_sub);
            se.due = cyc + 1 + sws[i];
            se.e   = {e[33:32], e[7:0]};
            swq[i].push_back(se);
          end
          if (sw_ov[i]) begin
            if (swq[i].size() == 0) begin
              chk("sw unexpected", 64'(sw_ov[i]), 64'(0));
            end else begin
              se = swq[i].pop_front();
              chk("sw result", {sw_of[i], sw_co[i], sw_sum[i]}, se.e);
              chk("sw latency", 64'(cyc), 64'(se.due));
            end
          end
        end
      end
    end
  end

  task automatic directed(string nm, logic [31:0] a, logic [31:0] b,
                          logic cin, logic sub,
                          logic [31:0] es, logic ec, logic eo);
    int n;
    chk({nm, " model"}, model(32, a, b, cin, sub), {eo, ec, es});
    in_a = a; in_b = b; in_cin = cin; in_sub = sub;
    in_valid = 1; out_ready = 1;
    @(posedge clk); #1;
    in_valid = 0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({nm, " latency"}, 64'(n), 64'(4));
    chk({nm, " out"}, {out_ovf, out_cout, out_sum}, {eo, ec, es});
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] pick();
    logic [31:0] cv [6] = '{32'h0, 32'h1, 32'h7FFFFFFF,
                            32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    if ($urandom_range(3) == 0) return cv[$urandom_range(5)];
    return $urandom;
  endfunction

  initial begin
    int cycles;
    int base;
    logic [7:0] cv8 [7] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};

    // reset state
    @(posedge clk); #1;
    chk("rst out_valid", 64'(out_valid), 64'(0));
    chk("rst in_ready", 64'(in_ready), 64'(0));
    chk("rst cnt", 64'(out_cnt), 64'(0));
    chk("rst out", {out_ovf, out_cout, out_sum}, 64'(0));
    @(posedge clk); #2;
    rst = 0;
    #1;
    chk("release in_ready", 64'(in_ready), 64'(1));
    @(posedge clk); #1;

    directed("add wrap", 32'hFFFFFFFF, 32'h1, 0, 0, 32'h0, 1, 0);
    directed("add ovf", 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1);
    directed("add cin", 32'h1, 32'h1, 1, 0, 32'h3, 0, 0);
    directed("sub neg", 32'h5, 32'h7, 0, 1, 32'hFFFFFFFE, 0, 0);
    directed("sub cin ign", 32'h5, 32'h7, 1, 1, 32'hFFFFFFFE, 0, 0);
    directed("sub ovf", 32'h80000000, 32'h1, 0, 1, 32'h7FFFFFFF, 1, 1);

    // random traffic with random backpressure
    base = n_acc;
    cycles = 0;
    while (n_acc < base + 1000 && cycles < 20000) begin
      in_valid = $urandom_range(1);
      in_a = pick(); in_b = pick();
      in_cin = $urandom_range(1); in_sub = $urandom_range(1);
      out_ready = $urandom_range(1);
      @(posedge clk); #1;
      cycles++;
    end
    chk("random accepted", 64'(n_acc - base >= 1000), 64'(1));
    in_valid = 0; out_ready = 1;
    repeat (10) @(posedge clk);
    #1;
    chk("random drain", 64'(exp_q.size()), 64'(0));

    // fill under full backpressure
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1; in_a = pick(); in_b = pick();
      in_cin = $urandom_range(1); in_sub = $urandom_range(1);
      @(posedge clk); #1;
    end
    chk("full cnt", 64'(out_cnt), 64'(5));
    chk("full in_ready", 64'(in_ready), 64'(0));
    chk("full out_valid", 64'(out_valid), 64'(1));
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    out_ready = 1;
    repeat (8) @(posedge clk);
    #1;
    chk("full drain", 64'(exp_q.size()), 64'(0));

    // reset with three ops in flight
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1; in_a = pick(); in_b = pick();
      in_cin = 0; in_sub = 0;
      @(posedge clk); #1;
    end
    in_valid = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre-rst cnt", 64'(out_cnt), 64'(3));
    chk("pre-rst out_valid", 64'(out_valid), 64'(1));
    #2;
    rst = 1;
    #1;
    chk("mid rst out_valid", 64'(out_valid), 64'(0));
    chk("mid rst cnt", 64'(out_cnt), 64'(0));
    chk("mid rst in_ready", 64'(in_ready), 64'(0));
    chk("mid rst out", {out_ovf, out_cout, out_sum}, 64'(0));
    out_ready = 1;
    @(posedge clk); @(posedge clk); #2;
    rst = 0;
    #1;
    chk("rerelease in_ready", 64'(in_ready), 64'(1));
    begin
      int seen;
      seen = 0;
      repeat (10) begin
        @(posedge clk); #1;
        if (out_valid) seen++;
      end
      chk("no stale", 64'(seen), 64'(0));
    end

    // WIDTH=8 sweep on STAGES=1,2,8
    sw_valid = 1;
    for (int a = 0; a < 256; a++) begin
      for (int bi = 0; bi < 52; bi++) begin
        sw_a = 8'(a); sw_b = 8'(bi * 5);
        sw_cin = 1'((a + bi) % 2); sw_sub = 1'(((a + bi) / 2) % 2);
        @(posedge clk); #1;
      end
    end
    for (int i = 0; i < 7; i++) begin
      for (int j = 0; j < 7; j++) begin
        for (int md = 0; md < 4; md++) begin
          sw_a = cv8[i]; sw_b = cv8[j];
          sw_cin = 1'(md % 2); sw_sub = 1'(md / 2);
          @(posedge clk); #1;
        end
      end
    end
    sw_valid = 0;
    repeat (12) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++)
      chk("sw drain", 64'(swq[i].size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: run did not finish, %0d tests, %0d failed",
             n_tests, n_fail);
    $fatal(1);
  end

endmodule
